// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions for the scan driver and decoder.
// Segment patterns are active low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

  localparam int NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001101;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CAPTURE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
  } sample_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Maps an active-low segment pattern back to its hex nibble.
// Blank and unknown patterns are flagged separately.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] nibble,
  output logic       is_blank,
  output logic       is_valid
);

  always_comb begin
    nibble   = 4'h0;
    is_blank = 1'b0;
    is_valid = 1'b1;
    case (segments)
      SEG_0: nibble = 4'h0;
      SEG_1: nibble = 4'h1;
      SEG_2: nibble = 4'h2;
      SEG_3: nibble = 4'h3;
      SEG_4: nibble = 4'h4;
      SEG_5: nibble = 4'h5;
      SEG_6: nibble = 4'h6;
      SEG_7: nibble = 4'h7;
      SEG_8: nibble = 4'h8;
      SEG_9: nibble = 4'h9;
      SEG_A: nibble = 4'hA;
      SEG_B: nibble = 4'hB;
      SEG_C: nibble = 4'hC;
      SEG_D: nibble = 4'hD;
      SEG_E: nibble = 4'hE;
      SEG_F: nibble = 4'hF;
      SEG_BLANK: begin
        is_valid = 1'b0;
        is_blank = 1'b1;
      end
      default: is_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers four hex digits from a multiplexed
// common-anode seven-segment display bus.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       an0,
  input  logic       an1,
  input  logic       an2,
  input  logic       an3,
  input  logic       ca,
  input  logic       cb,
  input  logic       cc,
  input  logic       cd,
  input  logic       ce,
  input  logic       cf,
  input  logic       cg,
  input  logic       dp,
  output logic [3:0] val0,
  output logic [3:0] val1,
  output logic [3:0] val2,
  output logic [3:0] val3,
  output logic [3:0] vld,
  output logic       frame_done,
  output logic       seg_err,
  output logic       an_err
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [11:0] sync_q [SYNC_STAGES];
  sample_t     cur;
  sample_t     prev_q;
  sample_t     held_q;
  logic        unused_dp;

  state_t      state_q, state_d;
  logic [SW-1:0] cnt_q, cnt_now;
  logic [TW-1:0] tcnt_q;

  logic [3:0]  val_q [NUM_DIGITS];
  logic [3:0]  val_d [NUM_DIGITS];
  logic [3:0]  vld_q, vld_d;
  logic [3:0]  seen_q, seen_d;
  logic        done_q, done_d;
  logic        serr_q, serr_d;
  logic        aerr_q, aerr_d;

  logic        any_low;
  logic [3:0]  an_low;
  logic        one_hot;
  logic [1:0]  idx;
  logic [3:0]  dec_nib;
  logic        dec_blank;
  logic        dec_valid;
  logic        timeout_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '1;
    end else begin
      sync_q[0] <= {an3, an2, an1, an0,
                    ca, cb, cc, cd, ce, cf, cg, dp};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
    end
  end

  assign cur       = sync_q[SYNC_STAGES-1][11:1];
  assign unused_dp = sync_q[SYNC_STAGES-1][0];
  assign any_low   = ~&cur.an;

  // Count includes the current sample, so S equal samples give S.
  always_comb begin
    cnt_now = SW'(1);
    if (cur == prev_q)
      cnt_now = (cnt_q == STAB_MAX) ? cnt_q : cnt_q + SW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (any_low) state_d = SETTLE;
      SETTLE:
        if (!any_low) state_d = IDLE;
        else if (cnt_now == STAB_MAX) state_d = CAPTURE;
      CAPTURE:
        state_d = HOLD;
      HOLD:
        if (cur != held_q) state_d = any_low ? SETTLE : IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // Capture works on prev_q: the last of the stable samples.
  seg7_pattern_decode u_dec (
    .segments (prev_q.seg),
    .nibble   (dec_nib),
    .is_blank (dec_blank),
    .is_valid (dec_valid)
  );

  assign an_low  = ~prev_q.an;
  assign one_hot = (an_low != 4'b0) &&
                   ((an_low & (an_low - 4'd1)) == 4'b0);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (an_low[i]) idx = i[1:0];
  end

  assign timeout_hit = (state_q == IDLE) && !any_low &&
                       (tcnt_q == TO_LAST);

  always_comb begin
    val_d  = val_q;
    vld_d  = vld_q;
    seen_d = seen_q;
    done_d = 1'b0;
    serr_d = 1'b0;
    aerr_d = 1'b0;
    if (state_q == CAPTURE) begin
      if (!one_hot) begin
        aerr_d = 1'b1;
      end else if (dec_valid || dec_blank) begin
        seen_d[idx] = 1'b1;
        vld_d[idx]  = dec_valid;
        if (dec_valid) val_d[idx] = dec_nib;
      end else begin
        serr_d = 1'b1;
      end
      if (&seen_d) begin
        done_d = 1'b1;
        seen_d = '0;
      end
    end else if (timeout_hit) begin
      vld_d  = '0;
      seen_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '1;
      held_q  <= '1;
      cnt_q   <= '0;
      tcnt_q  <= '0;
      for (int i = 0; i < NUM_DIGITS; i++)
        val_q[i] <= '0;
      vld_q   <= '0;
      seen_q  <= '0;
      done_q  <= 1'b0;
      serr_q  <= 1'b0;
      aerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= cur;
      cnt_q   <= cnt_now;
      if (state_q == CAPTURE) held_q <= prev_q;
      if (state_q != IDLE || any_low)
        tcnt_q <= '0;
      else if (tcnt_q != TO_MAX)
        tcnt_q <= tcnt_q + TW'(1);
      val_q   <= val_d;
      vld_q   <= vld_d;
      seen_q  <= seen_d;
      done_q  <= done_d;
      serr_q  <= serr_d;
      aerr_q  <= aerr_d;
    end
  end

  assign val0       = val_q[0];
  assign val1       = val_q[1];
  assign val2       = val_q[2];
  assign val3       = val_q[3];
  assign vld        = vld_q;
  assign frame_done = done_q;
  assign seg_err    = serr_q;
  assign an_err     = aerr_q;

endmodule
